// File: rtl/branch_pkg.sv
// Shared types for the execute-stage branch/flag control slice:
// condition opcodes, controller states and NZCV bit positions.
package branch_pkg;

  typedef enum logic [2:0] {
    COND_NV = 3'b000,
    COND_CS = 3'b001,
    COND_CC = 3'b010,
    COND_EQ = 3'b011,
    COND_NE = 3'b100,
    COND_GT = 3'b101,
    COND_LT = 3'b110,
    COND_AL = 3'b111
  } cond_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    REDIRECT
  } state_t;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/branch_flag_controller_if.sv
// Pipeline-side bundle of flag-writer, branch-request and redirect signals.
// master = execute/fetch pipeline, slave = branch_flag_controller.
interface branch_flag_controller_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              flag_issue;
  logic              flag_we;
  logic [3:0]        flags_in;
  logic              br_valid;
  logic [2:0]        br_cond;
  logic [ADDR_W-1:0] br_target;
  logic              br_ready;
  logic              stall;
  logic              pc_src;
  logic [ADDR_W-1:0] pc_target;
  logic              flush;
  logic [3:0]        flags_out;
  logic              pending_full;

  modport master (
    output flag_issue, flag_we, flags_in, br_valid, br_cond, br_target,
    input  br_ready, stall, pc_src, pc_target, flush, flags_out, pending_full
  );

  modport slave (
    input  flag_issue, flag_we, flags_in, br_valid, br_cond, br_target,
    output br_ready, stall, pc_src, pc_target, flush, flags_out, pending_full
  );
endinterface

// File: rtl/condition_checker.sv
// Evaluates a 3-bit branch condition opcode against NZCV flags.
module condition_checker
  import branch_pkg::*;
(
  input  cond_t opcode,
  input  logic  N,
  input  logic  Z,
  input  logic  C,
  input  logic  V,
  output logic  condEx
);

  always_comb begin
    condEx = 1'b0;
    case (opcode)
      COND_NV: condEx = 1'b0;
      COND_CS: condEx = C;
      COND_CC: condEx = !C;
      COND_EQ: condEx = Z;
      COND_NE: condEx = !Z;
      COND_GT: condEx = !Z && (N == V);
      COND_LT: condEx = (N != V);
      COND_AL: condEx = 1'b1;
      default: condEx = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_flag_controller.sv
// Owns the NZCV register and in-flight flag-writer count; holds conditional
// branches until flags are final, then resolves them and issues a redirect.
module branch_flag_controller
  import branch_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned PEND_W = 2
) (
  input logic                     clk,
  input logic                     rst,
  branch_flag_controller_if.slave bus
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  state_t            state;
  cond_t             cond_q;
  cond_t             sel_cond;
  logic [ADDR_W-1:0] target_q;
  logic [ADDR_W-1:0] pc_target_q;
  logic              pc_src_q;
  logic [3:0]        flags_q;
  logic [3:0]        eval_flags;
  logic [PEND_W-1:0] pending;
  logic              flags_ready;
  logic              cond_ex;

  always_comb begin
    flags_ready = (pending == '0) ||
                  ((pending == PEND_ONE) && bus.flag_we && !bus.flag_issue);
    eval_flags  = bus.flag_we ? bus.flags_in : flags_q;
    sel_cond    = (state == WAIT) ? cond_q : cond_t'(bus.br_cond);
  end

  condition_checker u_cond (
    .opcode (sel_cond),
    .N      (eval_flags[FLAG_N]),
    .Z      (eval_flags[FLAG_Z]),
    .C      (eval_flags[FLAG_C]),
    .V      (eval_flags[FLAG_V]),
    .condEx (cond_ex)
  );

  // Handshake outputs must react to a resolving flag_we in the same cycle,
  // so they are decoded from state; the redirect outputs are registered.
  always_comb begin
    bus.br_ready = 1'b0;
    bus.stall    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.br_valid) begin
          bus.br_ready = flags_ready;
          bus.stall    = !flags_ready;
        end
      end
      WAIT: begin
        bus.br_ready = flags_ready;
        bus.stall    = !flags_ready;
      end
      default: ;
    endcase
  end

  assign bus.pc_src       = pc_src_q;
  assign bus.flush        = pc_src_q;
  assign bus.pc_target    = pc_target_q;
  assign bus.flags_out    = flags_q;
  assign bus.pending_full = (pending == PEND_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flags_q <= '0;
      pending <= '0;
    end else begin
      if (bus.flag_we) flags_q <= bus.flags_in;
      case ({bus.flag_issue, bus.flag_we})
        2'b10:   if (pending != PEND_MAX) pending <= pending + PEND_ONE;
        2'b01:   if (pending != '0)       pending <= pending - PEND_ONE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cond_q      <= COND_NV;
      target_q    <= '0;
      pc_target_q <= '0;
      pc_src_q    <= 1'b0;
    end else begin
      pc_src_q    <= 1'b0;
      pc_target_q <= '0;
      case (state)
        IDLE: begin
          if (bus.br_valid) begin
            cond_q   <= cond_t'(bus.br_cond);
            target_q <= bus.br_target;
            if (!flags_ready) begin
              state <= WAIT;
            end else if (cond_ex) begin
              state       <= REDIRECT;
              pc_src_q    <= 1'b1;
              pc_target_q <= bus.br_target;
            end
          end
        end
        WAIT: begin
          if (flags_ready) begin
            if (cond_ex) begin
              state       <= REDIRECT;
              pc_src_q    <= 1'b1;
              pc_target_q <= target_q;
            end else begin
              state <= IDLE;
            end
          end
        end
        REDIRECT: state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_flag_controller.sv
// Directed plus randomized bench for branch_flag_controller against a
// cycle-level behavioural model of the branch/flag rules.
module tb_branch_flag_controller;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned PEND_W = 2;
  localparam int          PMAX   = (1 << PEND_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  branch_flag_controller_if #(.ADDR_W(ADDR_W)) bus ();

  branch_flag_controller #(.ADDR_W(ADDR_W), .PEND_W(PEND_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int          m_pend;
  logic [3:0]  m_flags;
  bit          m_wait;
  logic [2:0]  m_cond;
  logic [31:0] m_wtgt;
  bit          m_redir;
  logic [31:0] m_tgt;

  function automatic bit m_taken(input logic [2:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      3'd0:    return 1'b0;
      3'd1:    return cy;
      3'd2:    return !cy;
      3'd3:    return z;
      3'd4:    return !z;
      3'd5:    return !z && (n == v);
      3'd6:    return n != v;
      default: return 1'b1;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = 0; m_flags = '0; m_wait = 0; m_cond = '0;
    m_wtgt = '0; m_redir = 0; m_tgt = '0;
  endtask

  task automatic drive_idle();
    bus.flag_issue = 1'b0; bus.flag_we = 1'b0; bus.flags_in = '0;
    bus.br_valid = 1'b0; bus.br_cond = '0; bus.br_target = '0;
  endtask

  // One cycle: drive at posedge+1, check at posedge+3, advance model.
  task automatic step(input logic iss, input logic we, input logic [3:0] fin,
                      input logic valid, input logic [2:0] cond, input logic [31:0] tgt);
    bit rdy, e_ready, e_stall, nxt;
    logic [3:0] ev;
    bus.flag_issue = iss; bus.flag_we = we; bus.flags_in = fin;
    bus.br_valid = valid; bus.br_cond = cond; bus.br_target = tgt;
    #2;
    rdy = (m_pend == 0) || (m_pend == 1 && we && !iss);
    ev  = we ? fin : m_flags;
    chk("pc_src", 32'(bus.pc_src), 32'(m_redir));
    chk("flush", 32'(bus.flush), 32'(m_redir));
    if (m_redir) chk("pc_target", bus.pc_target, m_tgt);
    chk("flags_out", 32'(bus.flags_out), 32'(m_flags));
    chk("pending_full", 32'(bus.pending_full), 32'(m_pend == PMAX));
    e_ready = 0; e_stall = 0; nxt = 0;
    if (m_redir) begin
      // request presented during a redirect is flushed
    end else if (m_wait) begin
      if (rdy) begin
        e_ready = 1; m_wait = 0;
        nxt = m_taken(m_cond, ev); m_tgt = m_wtgt;
      end else e_stall = 1;
    end else if (valid) begin
      if (rdy) begin
        e_ready = 1; nxt = m_taken(cond, ev); m_tgt = tgt;
      end else begin
        e_stall = 1; m_wait = 1; m_cond = cond; m_wtgt = tgt;
      end
    end
    chk("br_ready", 32'(bus.br_ready), 32'(e_ready));
    chk("stall", 32'(bus.stall), 32'(e_stall));
    m_redir = nxt;
    if (we) m_flags = fin;
    if (iss && !we && m_pend < PMAX) m_pend++;
    else if (we && !iss && m_pend > 0) m_pend--;
    @(posedge clk); #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_br_ready"}, 32'(bus.br_ready), 32'd0);
    chk({tag, "_stall"}, 32'(bus.stall), 32'd0);
    chk({tag, "_pc_src"}, 32'(bus.pc_src), 32'd0);
    chk({tag, "_flush"}, 32'(bus.flush), 32'd0);
    chk({tag, "_pc_target"}, bus.pc_target, 32'd0);
    chk({tag, "_flags_out"}, 32'(bus.flags_out), 32'd0);
    chk({tag, "_pending_full"}, 32'(bus.pending_full), 32'd0);
  endtask

  initial begin
    drive_idle();
    model_reset();
    #1;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    // taken EQ with flags ready
    step(0, 1, 4'b0100, 0, 3'b000, 32'h0);
    step(0, 0, 4'b0000, 1, 3'b011, 32'h0000_1000);
    step(0, 0, 4'b0000, 0, 3'b000, 32'h0);
    step(0, 0, 4'b0000, 0, 3'b000, 32'h0);

    // not-taken EQ
    step(0, 1, 4'b0000, 0, 3'b000, 32'h0);
    step(0, 0, 4'b0000, 1, 3'b011, 32'h0000_2000);
    step(0, 0, 4'b0000, 0, 3'b000, 32'h0);

    // LT waits on one in-flight writer, br_valid dropped while waiting
    step(1, 0, 4'b0000, 0, 3'b000, 32'h0);
    step(0, 0, 4'b0000, 1, 3'b110, 32'hCAFE_0000);
    step(0, 0, 4'b0000, 0, 3'b000, 32'h0);
    step(0, 0, 4'b0000, 0, 3'b000, 32'h0);
    step(0, 1, 4'b1000, 0, 3'b000, 32'h0);
    step(0, 0, 4'b0000, 0, 3'b000, 32'h0);
    step(0, 0, 4'b0000, 0, 3'b000, 32'h0);

    // pending saturation, simultaneous issue+write, underflow
    repeat (4) step(1, 0, 4'b0000, 0, 3'b000, 32'h0);
    step(1, 1, 4'b0010, 0, 3'b000, 32'h0);
    step(0, 1, 4'b0011, 0, 3'b000, 32'h0);
    step(0, 1, 4'b0101, 0, 3'b000, 32'h0);
    step(0, 0, 4'b0000, 1, 3'b001, 32'h0000_3000);
    step(0, 1, 4'b0110, 0, 3'b000, 32'h0);
    step(0, 1, 4'b1111, 0, 3'b000, 32'h0);
    step(0, 0, 4'b0000, 0, 3'b000, 32'h0);

    // AL taken, request held through REDIRECT, then NV not taken
    step(0, 0, 4'b0000, 1, 3'b111, 32'h0000_4000);
    step(0, 0, 4'b0000, 1, 3'b111, 32'h0000_5000);
    step(0, 0, 4'b0000, 1, 3'b000, 32'h0000_6000);
    step(0, 0, 4'b0000, 0, 3'b000, 32'h0);

    // reset while in WAIT
    step(1, 0, 4'b0000, 0, 3'b000, 32'h0);
    step(0, 0, 4'b0000, 1, 3'b110, 32'h0000_7000);
    step(0, 0, 4'b0000, 0, 3'b000, 32'h0);
    drive_idle();
    rst = 1'b0;
    #1;
    check_all_zero("rst_wait");
    model_reset();
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    step(0, 0, 4'b0000, 0, 3'b000, 32'h0);
    step(0, 0, 4'b0000, 0, 3'b000, 32'h0);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
           4'($urandom_range(0, 15)), ($urandom_range(0, 1) == 1),
           3'($urandom_range(0, 7)), $urandom());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_flag_controller.md
Name: branch_flag_controller

Overview:
- Sequences the condition_checker in the execute stage.
- Owns the architectural NZCV flag register and a scoreboard of in-flight flag-writing instructions.
- Accepts conditional-branch requests, stalls them until flags are final, then resolves them through condition_checker.
- On a taken branch, drives a one-cycle PC redirect plus a pipeline flush to fetch/decode.

Parameters:
ADDR_W, 32, width of branch target / PC
PEND_W, 2, width of pending flag-writer counter (max 2^PEND_W-1 in flight)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset; one clock; reset is asynchronous and active-low
flag_issue  input  1  pulse: a flag-setting instruction entered execute pipeline
flag_we  input  1  pulse: ALU writes flags this cycle
flags_in  input  4  {N,Z,C,V} from ALU, valid with flag_we
br_valid  input  1  branch request valid
br_cond  input  3  condition opcode to condition_checker
br_target  input  ADDR_W  branch target address
br_ready  output  1  request accepted this cycle
stall  output  1  hold fetch/decode; branch waiting on flags
pc_src  output  1  select br target for next PC (one-cycle pulse)
pc_target  output  ADDR_W  registered target, valid when pc_src=1
flush  output  1  flush IF/ID and ID/EX (one-cycle pulse, coincident with pc_src)
flags_out  output  4  current architectural {N,Z,C,V}
pending_full  output  1  counter saturated; issue must stall flag-setters

Behaviour:
- Reset (rst=0, async): state IDLE, flags=0000, pending=0; br_ready, stall, pc_src, flush = 0; pc_target=0.
- Condition codes: 000 never, 001 C=1, 010 C=0, 011 EQ Z=1, 100 NE Z=0, 101 GT Z=0 && N==V, 110 LT N!=V, 111 always.
- Flag register: loads flags_in on flag_we, independent of state.
- Pending counter:
  - +1 on flag_issue; -1 on flag_we; both in the same cycle -> unchanged.
  - flag_we at 0 -> stays 0, flags still written.
  - flag_issue at max -> saturates, no wrap.
  - pending_full = (pending==max), combinational.
- flags_ready = (pending==0) || (pending==1 && flag_we && !flag_issue).
- Eval flags = flags_in if flag_we else the flag register (forwarding).
- State IDLE:
  - br_valid && flags_ready: br_ready=1; latch cond, target and condEx evaluated on eval flags.
    - condEx=1 -> REDIRECT.
    - condEx=0 -> stay IDLE, no redirect.
  - br_valid && !flags_ready: latch cond/target, stall=1, -> WAIT.
- State WAIT:
  - stall=1 every cycle.
  - When flags_ready: br_ready=1, evaluate latched cond; taken -> REDIRECT, else -> IDLE.
  - stall drops in the cycle br_ready=1.
- State REDIRECT:
  - pc_src=1, flush=1, pc_target=latched target for exactly one cycle; br_ready=0; -> IDLE.
  - A br_valid presented here is ignored (it is being flushed).
- Latency:
  - Taken with flags ready: accept at cycle T, pc_src/flush at T+1.
  - Waiting case: redirect one cycle after the resolving flag_we.
- br_valid deasserted while in WAIT: request already latched, still resolved.
- Reset mid-WAIT/REDIRECT: immediate return to IDLE, no redirect emitted after reset release.

Decomposition:
- Shared package branch_pkg holds:
  - cond_t enum (COND_NV..COND_AL, 3 bits).
  - state_t enum {IDLE, WAIT, REDIRECT}.
  - flag bit index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- One sub-module: condition_checker (ports opcode, N, Z, C, V, condEx), instantiated once, fed by a mux of live vs latched cond and eval flags.
- Pending scoreboard counter is inline, not a separate module.

Test Plan:
- Reset, then br_valid cond=011, pending=0, flags Z=1 -> br_ready at T, pc_src=flush=1 at T+1 with pc_target=br_target, back to IDLE at T+2.
- Same request with flags 0000, cond=011 -> br_ready=1, no pc_src/flush ever, stall=0.
- flag_issue once, then br_valid cond=110 -> stall=1. Three cycles later flag_we flags_in=1000 -> br_ready same cycle, pc_src next cycle, stall low after.
- Pending counter:
  - PEND_W=2: four flag_issue pulses -> pending saturates at 3, pending_full=1.
  - Simultaneous flag_issue+flag_we -> count unchanged.
  - flag_we at count 0 -> stays 0, flags_out updated.
- Reset asserted while in WAIT -> all outputs 0, flags_out=0000. Releasing reset with br_valid low -> no pc_src.
- cond=111 with flags 1111 and cond=000 with flags 1111 -> taken and not-taken respectively. br_valid held during REDIRECT -> no br_ready that cycle.
